// File: rtl/uart_pkg.sv
// Shared types and default widths for the UART transmit feeder.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int UART_ADDR_W = 4;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } feeder_state_e;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with registered full/empty flags and wrapping pointers.
module fifo_sync
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int ADDR_W = UART_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              rd,
    output logic [DATA_W-1:0] r_data,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_succ, rd_ptr_succ;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              wr_en, rd_en;

    // A write while full is dropped even if a pop happens in the same cycle.
    assign wr_en = wr & ~full_q;
    assign rd_en = rd & ~empty_q;

    assign wr_ptr_succ = wr_ptr_q + ADDR_W'(1);
    assign rd_ptr_succ = rd_ptr_q + ADDR_W'(1);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        full_d   = full_q;
        empty_d  = empty_q;
        unique case ({wr_en, rd_en})
            2'b10: begin
                wr_ptr_d = wr_ptr_succ;
                empty_d  = 1'b0;
                full_d   = (wr_ptr_succ == rd_ptr_q);
            end
            2'b01: begin
                rd_ptr_d = rd_ptr_succ;
                full_d   = 1'b0;
                empty_d  = (rd_ptr_succ == wr_ptr_q);
            end
            2'b11: begin
                wr_ptr_d = wr_ptr_succ;
                rd_ptr_d = rd_ptr_succ;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= w_data;
        end
    end

    assign r_data = mem_q[rd_ptr_q];
    assign full   = full_q;
    assign empty  = empty_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues bytes and hands them one at a time to a UART transmitter.
// Define UART_TX_FEEDER_OVF_CNT_EN to add the dropped-write counter ovf_cnt.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int ADDR_W = UART_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
    output logic              full,
    output logic              empty,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_din,
    input  logic              tx_done_tick,
    output logic              busy
`ifdef UART_TX_FEEDER_OVF_CNT_EN
    ,
    output logic [7:0]        ovf_cnt
`endif
);

    feeder_state_e     state_q, state_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_din_q, tx_din_d;
    logic [DATA_W-1:0] head;
    logic              pop;

    fifo_sync #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .w_data (w_data),
        .rd     (pop),
        .r_data (head),
        .full   (full),
        .empty  (empty)
    );

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_din_d   = tx_din_q;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    tx_din_d   = head;
                    tx_start_d = 1'b1;
                    state_d    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done_tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_din_q   <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_din_q   <= tx_din_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_din   = tx_din_q;
    // The start cycle is already the first WAIT_DONE cycle.
    assign busy     = (state_q == WAIT_DONE);

`ifdef UART_TX_FEEDER_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (wr && full && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_cnt_q <= 8'd0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule
